// File: rtl/pcs_pkg.sv
// pcs_pkg: shared constants, slot kinds and helpers for the 40GbE PCS TX path.
// Holds sync headers, the idle block type, the default marker interval and the slot enum.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [7:0] BLK_TYPE_IDLE = 8'h1E;

  localparam int AM_INTERVAL_DEF = 16384;

  localparam logic [255:0] IDLE_BLOCK_DEF =
    {4{56'h0, BLK_TYPE_IDLE}};

  typedef enum logic [1:0] {
    SLOT_DATA,
    SLOT_IDLE,
    SLOT_AM
  } slot_e;

  typedef enum logic {
    S_RESET,
    S_RUN
  } run_e;

  function automatic logic [1:0] slot_hdr(
    input slot_e s
  );
    return (s == SLOT_DATA) ? SYNC_DATA : SYNC_CTRL;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] x
  );
    return (&x) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/pcs_tx_scheduler_if.sv
// pcs_tx_scheduler_if: MAC-to-scheduler beat handshake (valid/ready, 4x64b payload).
// Ports: tx_enable, tx_data_valid, tx_data from the MAC; tx_data_ready back.
interface pcs_tx_scheduler_if;

  logic         tx_enable;
  logic         tx_data_valid;
  logic         tx_data_ready;
  logic [255:0] tx_data;

  modport master (
    output tx_enable,
    output tx_data_valid,
    output tx_data,
    input  tx_data_ready
  );

  modport slave (
    input  tx_enable,
    input  tx_data_valid,
    input  tx_data,
    output tx_data_ready
  );

endinterface

// File: rtl/pcs_am_interval_counter.sv
// pcs_am_interval_counter: reload down-counter marking alignment-marker slots.
// Ports: clk, rst_n, run_i (reset released), am_slot_o (this cycle), am_next_o (reg, next beat).
module pcs_am_interval_counter
  import pcs_pkg::*;
#(
  parameter int AM_INTERVAL = AM_INTERVAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic am_slot_o,
  output logic am_next_o
);

  localparam int CW = $clog2(AM_INTERVAL);
  localparam logic [CW-1:0] RELOAD = CW'(AM_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          am_next_q;

  // While still in reset the counter is parked at zero so the
  // first running cycle is a marker slot; phase is never carried
  // across a reset.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= RELOAD;
      am_next_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      am_next_q <= (cnt_d == '0);
    end
  end

  assign am_slot_o = run_i & (cnt_q == '0);
  assign am_next_o = am_next_q;

endmodule

// File: rtl/pcs_tx_scheduler.sv
// pcs_tx_scheduler: per-beat data/idle/marker slot sequencer, 1-cycle registered latency.
// Ports: core_clk, core_reset_n, mac (slave handshake), blk_valid/blk_data/blk_sync_hdr/blk_am,
// scrambler_en, am_next; with PCS_TX_STATS_EN also stat_clear and stat_{data,idle,am}_beats.
module pcs_tx_scheduler
  import pcs_pkg::*;
#(
  parameter int AM_INTERVAL = AM_INTERVAL_DEF,
  parameter logic [255:0] IDLE_BLOCK = IDLE_BLOCK_DEF
) (
  input  logic              core_clk,
  input  logic              core_reset_n,
  pcs_tx_scheduler_if.slave mac,
  output logic              blk_valid,
  output logic [255:0]      blk_data,
  output logic [1:0]        blk_sync_hdr,
  output logic              blk_am,
  output logic              scrambler_en,
  output logic              am_next
`ifdef PCS_TX_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [31:0]       stat_data_beats,
  output logic [31:0]       stat_idle_beats,
  output logic [31:0]       stat_am_beats
`endif
);

  run_e  state_q, state_d;
  logic  rst_done;
  logic  am_slot;
  logic  am_next_w;
  logic  xfer;
  slot_e slot;

  logic         valid_q, valid_d;
  logic [255:0] data_q, data_d;
  logic [1:0]   hdr_q, hdr_d;
  logic         am_q, am_d;
  logic         scr_q, scr_d;

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
    endcase
  end

  assign rst_done = (state_q == S_RUN);

  pcs_am_interval_counter #(
    .AM_INTERVAL(AM_INTERVAL)
  ) u_am_cnt (
    .clk       (core_clk),
    .rst_n     (core_reset_n),
    .run_i     (rst_done),
    .am_slot_o (am_slot),
    .am_next_o (am_next_w)
  );

  // am_slot already implies rst_done, so ~am_slot here is
  // the same as a non-zero marker counter.
  assign mac.tx_data_ready =
    rst_done & mac.tx_enable & ~am_slot;

  assign xfer = mac.tx_data_valid & mac.tx_data_ready;

  always_comb begin
    slot = SLOT_IDLE;
    unique case (1'b1)
      am_slot: slot = SLOT_AM;
      xfer:    slot = SLOT_DATA;
      default: slot = SLOT_IDLE;
    endcase
  end

  always_comb begin
    valid_d = rst_done;
    am_d    = 1'b0;
    hdr_d   = SYNC_CTRL;
    data_d  = '0;
    scr_d   = 1'b0;
    if (rst_done) begin
      am_d  = (slot == SLOT_AM);
      hdr_d = slot_hdr(slot);
      scr_d = (slot != SLOT_AM);
      unique case (slot)
        SLOT_DATA: data_d = mac.tx_data;
        SLOT_IDLE: data_d = IDLE_BLOCK;
        default:   data_d = '0;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hdr_q   <= SYNC_CTRL;
      am_q    <= 1'b0;
      scr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      am_q    <= am_d;
      scr_q   <= scr_d;
    end
  end

  assign blk_valid    = valid_q;
  assign blk_data     = data_q;
  assign blk_sync_hdr = hdr_q;
  assign blk_am       = am_q;
  assign scrambler_en = scr_q;
  assign am_next      = am_next_w;

`ifdef PCS_TX_STATS_EN
  logic [31:0] st_data_q;
  logic [31:0] st_idle_q;
  logic [31:0] st_am_q;

  // Counted at the edge that registers the beat, so the
  // counters match the beats visible on blk_* one cycle later.
  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      st_data_q <= '0;
      st_idle_q <= '0;
      st_am_q   <= '0;
    end else if (stat_clear) begin
      st_data_q <= '0;
      st_idle_q <= '0;
      st_am_q   <= '0;
    end else if (rst_done) begin
      if (slot == SLOT_DATA) st_data_q <= sat_inc(st_data_q);
      if (slot == SLOT_IDLE) st_idle_q <= sat_inc(st_idle_q);
      if (slot == SLOT_AM)   st_am_q   <= sat_inc(st_am_q);
    end
  end

  assign stat_data_beats = st_data_q;
  assign stat_idle_beats = st_idle_q;
  assign stat_am_beats   = st_am_q;
`endif

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// tb_pcs_tx_scheduler: random-stimulus bench for two schedulers (AM_INTERVAL 8 and 2).
// Reference model: beat index since reset release, marker when index mod interval is 0.
module tb_pcs_tx_scheduler;
  import pcs_pkg::*;

  localparam logic [255:0] IDLE = {4{56'h0, 8'h1E}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  pcs_tx_scheduler_if m8();
  pcs_tx_scheduler_if m2();

  logic         en [2];
  logic         vld [2];
  logic [255:0] dat [2];
  logic         rdy [2];
  logic         bv [2];
  logic         bam [2];
  logic         scr [2];
  logic         amn [2];
  logic [1:0]   hdr [2];
  logic [255:0] bd [2];

  assign m8.tx_enable     = en[0];
  assign m8.tx_data_valid = vld[0];
  assign m8.tx_data       = dat[0];
  assign rdy[0]           = m8.tx_data_ready;
  assign m2.tx_enable     = en[1];
  assign m2.tx_data_valid = vld[1];
  assign m2.tx_data       = dat[1];
  assign rdy[1]           = m2.tx_data_ready;

`ifdef PCS_TX_STATS_EN
  logic        sclr = 1'b0;
  logic        sclr_nxt = 1'b0;
  logic [31:0] sd [2];
  logic [31:0] si [2];
  logic [31:0] sa [2];
  logic [31:0] m_sd [2];
  logic [31:0] m_si [2];
  logic [31:0] m_sa [2];
`endif

  pcs_tx_scheduler #(.AM_INTERVAL(8)) u8 (
    .core_clk     (clk),
    .core_reset_n (rst_n),
    .mac          (m8.slave),
    .blk_valid    (bv[0]),
    .blk_data     (bd[0]),
    .blk_sync_hdr (hdr[0]),
    .blk_am       (bam[0]),
    .scrambler_en (scr[0]),
    .am_next      (amn[0])
`ifdef PCS_TX_STATS_EN
    ,
    .stat_clear      (sclr),
    .stat_data_beats (sd[0]),
    .stat_idle_beats (si[0]),
    .stat_am_beats   (sa[0])
`endif
  );

  pcs_tx_scheduler #(.AM_INTERVAL(2)) u2 (
    .core_clk     (clk),
    .core_reset_n (rst_n),
    .mac          (m2.slave),
    .blk_valid    (bv[1]),
    .blk_data     (bd[1]),
    .blk_sync_hdr (hdr[1]),
    .blk_am       (bam[1]),
    .scrambler_en (scr[1]),
    .am_next      (amn[1])
`ifdef PCS_TX_STATS_EN
    ,
    .stat_clear      (sclr),
    .stat_data_beats (sd[1]),
    .stat_idle_beats (si[1]),
    .stat_am_beats   (sa[1])
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  int   nn [2] = '{8, 2};
  bit   rd [2];
  int   k [2];
  int   seq [2];
  bit   adv [2];
  logic e_v [2];
  logic e_am [2];
  logic e_scr [2];
  logic e_amn [2];
  logic [1:0] e_hdr [2];
  int   e_kind [2];
  logic [255:0] sb0 [$];
  logic [255:0] sb1 [$];

  logic rst_nxt = 1'b0;
  logic en_nxt [2];
  logic vld_nxt [2];

  function automatic logic [255:0] mkdat(input int s);
    logic [255:0] t;
    t = '0;
    for (int j = 1; j < 8; j++) t[j*32 +: 32] = $urandom;
    t[31:0] = 32'(s);
    return t;
  endfunction

  task automatic model_reset(input int i);
    rd[i]     = 1'b0;
    k[i]      = 0;
    e_v[i]    = 1'b0;
    e_am[i]   = 1'b0;
    e_scr[i]  = 1'b0;
    e_amn[i]  = 1'b0;
    e_hdr[i]  = 2'b01;
    e_kind[i] = 0;
    if (i == 0) sb0.delete(); else sb1.delete();
`ifdef PCS_TX_STATS_EN
    m_sd[i] = '0;
    m_si[i] = '0;
    m_sa[i] = '0;
`endif
  endtask

  function automatic logic m_ready(input int i);
    return rst_n && rd[i] && en[i] && (k[i] % nn[i] != 0);
  endfunction

  task automatic check(input int i);
    logic [255:0] ed;
    ed = '0;
    chk($sformatf("ready%0d", i), 256'(rdy[i]), 256'(m_ready(i)));
    chk($sformatf("valid%0d", i), 256'(bv[i]), 256'(e_v[i]));
    chk($sformatf("am%0d", i), 256'(bam[i]), 256'(e_am[i]));
    chk($sformatf("scr%0d", i), 256'(scr[i]), 256'(e_scr[i]));
    chk($sformatf("amnext%0d", i), 256'(amn[i]), 256'(e_amn[i]));
    chk($sformatf("hdr%0d", i), 256'(hdr[i]), 256'(e_hdr[i]));
    if (e_kind[i] == 1) ed = IDLE;
    if (e_kind[i] == 2) begin
      ed = '1;
      if (i == 0 && sb0.size() > 0) ed = sb0.pop_front();
      if (i == 1 && sb1.size() > 0) ed = sb1.pop_front();
    end
    chk($sformatf("data%0d", i), bd[i], ed);
`ifdef PCS_TX_STATS_EN
    chk($sformatf("st_data%0d", i), 256'(sd[i]), 256'(m_sd[i]));
    chk($sformatf("st_idle%0d", i), 256'(si[i]), 256'(m_si[i]));
    chk($sformatf("st_am%0d", i), 256'(sa[i]), 256'(m_sa[i]));
`endif
  endtask

  // Advance the model across the coming rising edge.
  task automatic update(input int i);
    bit am, acc;
    int kn;
    if (!rst_n) return;
    am  = rd[i] && (k[i] % nn[i] == 0);
    acc = vld[i] && m_ready(i);
`ifdef PCS_TX_STATS_EN
    if (sclr) begin
      m_sd[i] = '0;
      m_si[i] = '0;
      m_sa[i] = '0;
    end else if (rd[i]) begin
      if (am) m_sa[i]++;
      else if (acc) m_sd[i]++;
      else m_si[i]++;
    end
`endif
    e_v[i]   = rd[i];
    e_am[i]  = am;
    e_scr[i] = rd[i] && !am;
    e_hdr[i] = acc ? 2'b10 : 2'b01;
    e_kind[i] = !rd[i] ? 0 : am ? 3 : acc ? 2 : 1;
    if (acc) begin
      if (i == 0) sb0.push_back(dat[i]);
      else sb1.push_back(dat[i]);
      adv[i] = 1'b1;
    end
    kn = rd[i] ? k[i] + 1 : 0;
    e_amn[i] = (kn % nn[i] == 0);
    k[i]  = kn;
    rd[i] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    rst_n = rst_nxt;
`ifdef PCS_TX_STATS_EN
    sclr = sclr_nxt;
`endif
    for (int i = 0; i < 2; i++) begin
      en[i]  = en_nxt[i];
      vld[i] = vld_nxt[i];
      if (adv[i]) begin
        seq[i]++;
        dat[i] = mkdat(seq[i]);
        adv[i] = 1'b0;
      end
    end
    #1;
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end
    for (int i = 0; i < 2; i++) begin
      check(i);
      update(i);
    end
  endtask

  task automatic run(input int n, input logic e, input logic v);
    for (int i = 0; i < 2; i++) begin
      en_nxt[i]  = e;
      vld_nxt[i] = v;
    end
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      seq[i] = 0;
      adv[i] = 1'b0;
      dat[i] = mkdat(0);
      en[i]  = 1'b0;
      vld[i] = 1'b0;
      model_reset(i);
    end
    rst_nxt = 1'b0;
    run(3, 1'b0, 1'b0);
    rst_nxt = 1'b1;
    run(20, 1'b1, 1'b0);
    run(30, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    run(10, 1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (rd[0] && (k[0] % 8 == 4)) break;
      tick();
    end
    rst_nxt = 1'b0;
    run(3, 1'b1, 1'b1);
    rst_nxt = 1'b1;
    run(12, 1'b1, 1'b1);
`ifdef PCS_TX_STATS_EN
    rst_nxt = 1'b0;
    run(2, 1'b1, 1'b1);
    rst_nxt = 1'b1;
    run(65, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("st64_am8", 256'(sa[0]), 256'(8));
    chk("st64_data8", 256'(sd[0]), 256'(56));
    chk("st64_idle8", 256'(si[0]), 256'(0));
    chk("st64_am2", 256'(sa[1]), 256'(32));
    chk("st64_data2", 256'(sd[1]), 256'(32));
    sclr_nxt = 1'b1;
    run(1, 1'b1, 1'b1);
    sclr_nxt = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_data", 256'(sd[0]), 256'(0));
    chk("clr_am", 256'(sa[0]), 256'(0));
    chk("clr_idle", 256'(si[1]), 256'(0));
`endif
    begin
      int rc;
      rc = 0;
      for (int c = 0; c < 2000; c++) begin
        if (rc > 0) begin
          rc--;
          rst_nxt = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
          rc = $urandom_range(0, 2);
          rst_nxt = 1'b0;
        end else begin
          rst_nxt = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
          en_nxt[i]  = ($urandom_range(0, 9) != 0);
          vld_nxt[i] = ($urandom_range(0, 3) != 0);
        end
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
